// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer for a single-cycle datapath. It decodes
//            the fetched opcode (sequential / j / beq / bne / halt), resolves
//            branches with the datapath compare flag, sequences IDLE/RUN/HALT
//            and counts retired instructions.
// Options  : PCSEQ_BOUND_CHECK_EN - when defined, a computed next pc above
//            MAX_PC halts the sequencer with err=1.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] MAX_PC   = 32'h0000_03FC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic [31:0] instruction,
  input  logic        cmp_eq,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        halted,
  output logic        err,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [5:0] c_OP_J    = 6'b000010;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_BNE  = 6'b000101;
  localparam logic [5:0] c_OP_HALT = 6'b111111;

`ifdef PCSEQ_BOUND_CHECK_EN
  localparam logic c_BOUND_EN = 1'b1;
`else
  localparam logic c_BOUND_EN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_retired;
  logic [31:0] w_retired_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic        r_pc_valid;
  logic        r_halted;

  logic [5:0]  w_opcode;
  logic [31:0] w_pc_inc;
  logic [31:0] w_br_off;
  logic [31:0] w_target;
  logic        w_taken;
  logic        w_bound_viol;

  assign w_opcode = instruction[31:26];
  assign w_pc_inc = r_pc + PC_STEP;
  // Word offset: sign-extend the 16-bit immediate and scale to bytes.
  assign w_br_off = {{14{instruction[15]}}, instruction[15:0], 2'b00};

  // The comparison is always built; the build option decides if it matters.
  assign w_bound_viol = c_BOUND_EN & (w_target > MAX_PC);

  // Next-pc candidate for a non-halt instruction completing this cycle.
  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc_inc;
    case (w_opcode)
      c_OP_J:   w_target = {w_pc_inc[31:28], instruction[25:0], 2'b00};
      c_OP_BEQ: w_taken  = cmp_eq;
      c_OP_BNE: w_taken  = ~cmp_eq;
      default:  w_taken  = 1'b0;
    endcase
    if (w_taken) begin
      w_target = w_pc_inc + w_br_off;
    end
  end

  // Sequencing: stall outranks decode, halt holds pc, restart from HALT.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_retired_nxt = r_retired;
    w_err_nxt     = r_err;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (w_opcode == c_OP_HALT) begin
            w_state_nxt = S_HALT;
          end else begin
            w_retired_nxt = r_retired + 32'd1;
            if (w_bound_viol) begin
              w_state_nxt = S_HALT;
              w_err_nxt   = 1'b1;
            end else begin
              w_pc_nxt = w_target;
            end
          end
        end
      end
      S_HALT: begin
        if (start) begin
          w_state_nxt   = S_RUN;
          w_pc_nxt      = RESET_PC;
          w_retired_nxt = 32'd0;
          w_err_nxt     = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  // State and output registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_retired  <= 32'd0;
      r_err      <= 1'b0;
      r_pc_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_retired  <= w_retired_nxt;
      r_err      <= w_err_nxt;
      r_pc_valid <= (w_state_nxt == S_RUN);
      r_halted   <= (w_state_nxt == S_HALT);
    end
  end

  assign pc       = r_pc;
  assign pc_valid = r_pc_valid;
  assign halted   = r_halted;
  assign err      = r_err;
  assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer: directed scenarios plus a
//            randomized run compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] MAX_PC   = 32'h0000_03FC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic [31:0] instruction;
  logic        cmp_eq;
  logic [31:0] pc;
  logic        pc_valid;
  logic        halted;
  logic        err;
  logic [31:0] retired;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: mode 0=idle, 1=running, 2=halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_err;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP),
    .MAX_PC   (MAX_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .instruction (instruction),
    .cmp_eq      (cmp_eq),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .halted      (halted),
    .err         (err),
    .retired     (retired)
  );

  // Apply one clock of the architectural rules to the model.
  task automatic model_step();
    logic [5:0]  op;
    logic [31:0] seq;
    logic [31:0] nxt;
    int          simm;
    bit          bound_on;
`ifdef PCSEQ_BOUND_CHECK_EN
    bound_on = 1'b1;
`else
    bound_on = 1'b0;
`endif
    if (!rst_n) begin
      m_mode = 0; m_pc = RESET_PC; m_ret = 0; m_err = 1'b0;
      return;
    end
    op   = instruction[31:26];
    seq  = m_pc + PC_STEP;
    simm = $signed(instruction[15:0]);
    case (m_mode)
      0: if (start) m_mode = 1;
      1: begin
        if (!stall) begin
          if (op == 6'd63) begin
            m_mode = 2;
          end else begin
            if (op == 6'd2)
              nxt = (seq & 32'hF000_0000) | (32'(instruction[25:0]) * 32'd4);
            else if ((op == 6'd4 && cmp_eq) || (op == 6'd5 && !cmp_eq))
              nxt = seq + 32'(simm * 4);
            else
              nxt = seq;
            m_ret = m_ret + 1;
            if (bound_on && nxt > MAX_PC) begin
              m_mode = 2; m_err = 1'b1;
            end else begin
              m_pc = nxt;
            end
          end
        end
      end
      default: begin
        if (start) begin
          m_mode = 1; m_pc = RESET_PC; m_ret = 0; m_err = 1'b0;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic go_run();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; instruction = '0; cmp_eq = 1'b0;
    tick();
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      instruction = {6'd0, 26'($urandom)};
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; stall = 1'b0; instruction = 32'hFC00_0000; cmp_eq = 1'b1;
    tick();
    vectors++;
    if ({pc, pc_valid, halted, err, retired} !== {RESET_PC, 3'b000, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_state: pc=%h v=%b h=%b e=%b ret=%0d expected pc=%h v=0 h=0 e=0 ret=0",
               pc, pc_valid, halted, err, retired, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    go_run();
    vectors++;
    if (pc !== 32'd0 || pc_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL seq_start: pc=%h v=%b expected pc=0 v=1", pc, pc_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      nops(1);
      vectors++;
      if (pc !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL seq_pc[%0d]: pc=%h expected %h", i, pc, 32'(4 * i));
      end
    end
    vectors++;
    if (retired !== 32'd4 || pc_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL seq_retired: ret=%0d v=%b expected ret=4 v=1", retired, pc_valid);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [4] = '{6'b000100, 6'b000100, 6'b000100, 6'b000101};
    logic        cmps[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] imms[4] = '{16'h0003, 16'hFFFF, 16'h0003, 16'h0003};
    logic [31:0] exps[4] = '{32'd24, 32'd8, 32'd12, 32'd24};
    for (int k = 0; k < 4; k++) begin
      go_run();
      nops(2);
      instruction = {ops[k], 10'($urandom), imms[k]};
      cmp_eq = cmps[k];
      tick();
      cmp_eq = 1'b0;
      vectors++;
      if (pc !== exps[k] || retired !== 32'd3) begin
        miscompares++;
        $display("FAIL branch[%0d]: pc=%h ret=%0d expected pc=%h ret=3", k, pc, retired, exps[k]);
      end
    end
  endtask

  task automatic test_jump();
    go_run();
    nops(8);
    instruction = {6'b000010, 26'h000_0010};
    tick();
    vectors++;
    if (pc !== 32'h40 || retired !== 32'd9) begin
      miscompares++;
      $display("FAIL jump: pc=%h ret=%0d expected pc=00000040 ret=9", pc, retired);
    end
  endtask

  task automatic test_stall();
    go_run();
    nops(4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instruction = (i == 2) ? 32'hFC00_0000 : {6'd0, 26'($urandom)};
      tick();
      vectors++;
      if (pc !== 32'h10 || retired !== 32'd4 || pc_valid !== 1'b1 || halted !== 1'b0) begin
        miscompares++;
        $display("FAIL stall[%0d]: pc=%h ret=%0d v=%b h=%b expected pc=10 ret=4 v=1 h=0",
                 i, pc, retired, pc_valid, halted);
      end
    end
    stall = 1'b0;
    nops(1);
    vectors++;
    if (pc !== 32'h14 || retired !== 32'd5) begin
      miscompares++;
      $display("FAIL stall_release: pc=%h ret=%0d expected pc=14 ret=5", pc, retired);
    end
  endtask

  task automatic test_halt();
    go_run();
    nops(4);
    instruction = {6'b111111, 26'($urandom)};
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (pc !== 32'h10 || halted !== 1'b1 || pc_valid !== 1'b0 || retired !== 32'd4) begin
        miscompares++;
        $display("FAIL halt_hold[%0d]: pc=%h h=%b v=%b ret=%0d expected pc=10 h=1 v=0 ret=4",
                 i, pc, halted, pc_valid, retired);
      end
      instruction = $urandom;
      stall = 1'($urandom);
      tick();
    end
    stall = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (pc !== RESET_PC || retired !== 32'd0 || pc_valid !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_restart: pc=%h ret=%0d v=%b h=%b expected pc=0 ret=0 v=1 h=0",
               pc, retired, pc_valid, halted);
    end
  endtask

  task automatic test_reset_midrun();
    go_run();
    nops(11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (pc !== RESET_PC || retired !== 32'd0 || pc_valid !== 1'b0 || halted !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_midrun[%0d]: pc=%h ret=%0d v=%b h=%b expected pc=0 ret=0 v=0 h=0",
                 i, pc, retired, pc_valid, halted);
      end
      nops(1);
    end
  endtask

`ifdef PCSEQ_BOUND_CHECK_EN
  task automatic test_bound();
    go_run();
    nops(255);
    vectors++;
    if (pc !== 32'h3FC || err !== 1'b0) begin
      miscompares++;
      $display("FAIL bound_edge: pc=%h err=%b expected pc=3fc err=0", pc, err);
    end
    nops(1);
    vectors++;
    if (pc !== 32'h3FC || err !== 1'b1 || halted !== 1'b1 || retired !== 32'd256) begin
      miscompares++;
      $display("FAIL bound_trip: pc=%h err=%b h=%b ret=%0d expected pc=3fc err=1 h=1 ret=256",
               pc, err, halted, retired);
    end
  endtask
`else
  task automatic test_bound();
    go_run();
    instruction = {6'b000100, 10'd0, 16'hFFFE};
    cmp_eq = 1'b1;
    tick();
    cmp_eq = 1'b0;
    vectors++;
    if (pc !== 32'hFFFF_FFFC || err !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_back: pc=%h err=%b expected pc=fffffffc err=0", pc, err);
    end
    nops(1);
    vectors++;
    if (pc !== 32'd0 || retired !== 32'd2) begin
      miscompares++;
      $display("FAIL wrap_fwd: pc=%h ret=%0d expected pc=0 ret=2", pc, retired);
    end
  endtask
`endif

  task automatic test_random();
    logic [5:0] op;
    int         r;
    go_run();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      start = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 15);
      if (r < 6)       op = 6'd0;
      else if (r < 8)  op = 6'b000010;
      else if (r < 10) op = 6'b000100;
      else if (r < 12) op = 6'b000101;
      else if (r == 12) op = 6'b111111;
      else             op = 6'($urandom);
      instruction = {op, 26'($urandom)};
      cmp_eq = 1'($urandom);
      tick();
      vectors++;
      if ({pc, pc_valid, halted, err, retired} !==
          {m_pc, (m_mode == 1), (m_mode == 2), m_err, m_ret}) begin
        miscompares++;
        $display("FAIL random[%0d]: pc=%h v=%b h=%b e=%b ret=%0d expected pc=%h v=%b h=%b e=%b ret=%0d",
                 i, pc, pc_valid, halted, err, retired,
                 m_pc, (m_mode == 1), (m_mode == 2), m_err, m_ret);
      end
    end
  endtask

  initial begin
    m_mode = 0; m_pc = RESET_PC; m_ret = 0; m_err = 1'b0;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; instruction = '0; cmp_eq = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_halt();
    test_reset_midrun();
    test_bound();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
